// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Constants shared by the UART blocks.
//   UART_DATA_W      default byte width used by the receiver and its FIFO
//   UART_FIFO_DEPTH  default receive FIFO depth (power of two, >= 2)
// ----------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_DATA_W     = 8;
    localparam int UART_FIFO_DEPTH = 16;

endpackage : uart_pkg

// File: rtl/uart_fifo_mem.sv
// ----------------------------------------------------------------------------
// uart_fifo_mem
// Depth x DataWidth register array for the receive FIFO. The array is not
// reset: stale entries are never visible because the pointer logic only reads
// locations that have been written since the last reset.
// Ports:
//   clk_i   in   1          system clock
//   we      in   1          write enable
//   waddr   in   AddrWidth  write address
//   wdata   in   DataWidth  write data
//   raddr   in   AddrWidth  read address (asynchronous read)
//   rdata   out  DataWidth  read data
// ----------------------------------------------------------------------------
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int DataWidth = UART_DATA_W,
    parameter int Depth     = UART_FIFO_DEPTH,
    localparam int AddrWidth = $clog2(Depth)
) (
    input  logic                 clk_i,
    input  logic                 we,
    input  logic [AddrWidth-1:0] waddr,
    input  logic [DataWidth-1:0] wdata,
    input  logic [AddrWidth-1:0] raddr,
    output logic [DataWidth-1:0] rdata
);

    logic [DataWidth-1:0] mem [Depth];

    always_ff @(posedge clk_i) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule : uart_fifo_mem

// File: rtl/uart_rx_fifo.sv
// ----------------------------------------------------------------------------
// uart_rx_fifo
// Receive buffer placed directly after the UART receiver. Every byte flagged
// by the receiver's one-cycle rx_dv_i strobe is queued in a circular FIFO and
// offered to the bus side through a first-word fall-through valid/ready port.
// Also keeps a registered fill level and a sticky overflow flag.
//
// Build option: define UART_RX_FIFO_IRQ_EN to add the thresh_i / irq_o
// threshold interrupt. Without it those ports and their logic do not exist.
//
// Ports:
//   clk_i       in   1            system clock
//   rst_i       in   1            asynchronous, active-high reset
//   rx_dv_i     in   1            write strobe from the receiver
//   rx_data_i   in   DataWidth    received byte, valid with rx_dv_i
//   rd_valid_o  out  1            FIFO non-empty, rd_data_o holds the head
//   rd_ready_i  in   1            consumer takes the head byte
//   rd_data_o   out  DataWidth    head byte, 0 while empty
//   level_o     out  AddrWidth+1  number of stored bytes, 0..Depth
//   overflow_o  out  1            sticky: a byte was dropped while full
//   ovf_clr_i   in   1            clears overflow_o (a same-cycle drop wins)
//   thresh_i    in   AddrWidth+1  interrupt threshold (IRQ build only)
//   irq_o       out  1            level >= thresh_i, thresh_i != 0 (IRQ build only)
// ----------------------------------------------------------------------------
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DataWidth = UART_DATA_W,
    parameter int Depth     = UART_FIFO_DEPTH,
    localparam int AddrWidth = $clog2(Depth)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 rx_dv_i,
    input  logic [DataWidth-1:0] rx_data_i,
    output logic                 rd_valid_o,
    input  logic                 rd_ready_i,
    output logic [DataWidth-1:0] rd_data_o,
    output logic [AddrWidth:0]   level_o,
    output logic                 overflow_o,
`ifdef UART_RX_FIFO_IRQ_EN
    input  logic                 ovf_clr_i,
    input  logic [AddrWidth:0]   thresh_i,
    output logic                 irq_o
`else
    input  logic                 ovf_clr_i
`endif
);

    localparam int PtrWidth = AddrWidth + 1;
    localparam logic [PtrWidth-1:0] PtrOne = PtrWidth'(1);

    logic [PtrWidth-1:0]  wr_ptr, rd_ptr;
    logic [PtrWidth-1:0]  wr_ptr_next, rd_ptr_next;
    logic [PtrWidth-1:0]  level_q;
    logic [PtrWidth-1:0]  level_next;
    logic                 overflow_q;
    logic                 empty, full;
    logic                 push, pop, drop;
    logic [DataWidth-1:0] mem_rdata;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AddrWidth] != rd_ptr[AddrWidth]) &&
                   (wr_ptr[AddrWidth-1:0] == rd_ptr[AddrWidth-1:0]);

    // A pop frees a slot in the same cycle, so a full FIFO can still accept.
    assign pop  = rd_valid_o && rd_ready_i;
    assign push = rx_dv_i && (!full || pop);
    assign drop = rx_dv_i && full && !pop;

    assign wr_ptr_next = push ? (wr_ptr + PtrOne) : wr_ptr;
    assign rd_ptr_next = pop  ? (rd_ptr + PtrOne) : rd_ptr;
    assign level_next  = wr_ptr_next - rd_ptr_next;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            wr_ptr  <= wr_ptr_next;
            rd_ptr  <= rd_ptr_next;
            level_q <= level_next;
        end
    end

    // Set has priority over clear so a drop is never lost.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            overflow_q <= 1'b0;
        end else if (drop) begin
            overflow_q <= 1'b1;
        end else if (ovf_clr_i) begin
            overflow_q <= 1'b0;
        end
    end

    uart_fifo_mem #(
        .DataWidth (DataWidth),
        .Depth     (Depth)
    ) u_mem (
        .clk_i (clk_i),
        .we    (push),
        .waddr (wr_ptr[AddrWidth-1:0]),
        .wdata (rx_data_i),
        .raddr (rd_ptr[AddrWidth-1:0]),
        .rdata (mem_rdata)
    );

    // Read data is forced to 0 while empty so the bus never sees stale bytes.
    assign rd_valid_o = !empty;
    assign rd_data_o  = empty ? '0 : mem_rdata;
    assign level_o    = level_q;
    assign overflow_o = overflow_q;

`ifdef UART_RX_FIFO_IRQ_EN
    // Evaluated on the post-update level so irq_o moves together with level_o.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            irq_o <= 1'b0;
        end else begin
            irq_o <= (thresh_i != '0) && (level_next >= thresh_i);
        end
    end
`endif

endmodule : uart_rx_fifo

// File: tb/tb_uart_rx_fifo.sv
// ----------------------------------------------------------------------------
// tb_uart_rx_fifo
// Directed testbench for uart_rx_fifo (default DataWidth=8, Depth=16).
// Inputs change 1 time unit after the rising edge; outputs are checked just
// before the following edge. Define UART_RX_FIFO_IRQ_EN to also exercise the
// threshold interrupt.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_rx_fifo;

    logic       clk;
    logic       rst;
    logic       rx_dv;
    logic [7:0] rx_data;
    logic       rd_valid;
    logic       rd_ready;
    logic [7:0] rd_data;
    logic [4:0] level;
    logic       overflow;
    logic       ovf_clr;
`ifdef UART_RX_FIFO_IRQ_EN
    logic [4:0] thresh;
    logic       irq;
`endif

    int errors = 0;
    int checks = 0;

    uart_rx_fifo dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .rx_dv_i    (rx_dv),
        .rx_data_i  (rx_data),
        .rd_valid_o (rd_valid),
        .rd_ready_i (rd_ready),
        .rd_data_o  (rd_data),
        .level_o    (level),
        .overflow_o (overflow),
`ifdef UART_RX_FIFO_IRQ_EN
        .ovf_clr_i  (ovf_clr),
        .thresh_i   (thresh),
        .irq_o      (irq)
`else
        .ovf_clr_i  (ovf_clr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle: inputs set before this call are sampled at the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b1;
        rx_dv    = 1'b0;
        rx_data  = 8'h00;
        rd_ready = 1'b0;
        ovf_clr  = 1'b0;
`ifdef UART_RX_FIFO_IRQ_EN
        thresh   = 5'd0;
`endif
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Reset state
        check("rst_level", 32'(level), 32'd0);
        check("rst_valid", 32'(rd_valid), 32'd0);
        check("rst_data", 32'(rd_data), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
`ifdef UART_RX_FIFO_IRQ_EN
        check("rst_irq", 32'(irq), 32'd0);
`endif

        // Test 1: three writes, then in-order reads
        rx_dv = 1'b1; rx_data = 8'hA5;
        tick();
        check("t1_valid_lat", 32'(rd_valid), 32'd1);
        check("t1_level1", 32'(level), 32'd1);
        check("t1_head_first", 32'(rd_data), 32'hA5);
        rx_data = 8'h3C;
        tick();
        rx_data = 8'h7E;
        tick();
        rx_dv = 1'b0;
        check("t1_level3", 32'(level), 32'd3);
        check("t1_head", 32'(rd_data), 32'hA5);
        rd_ready = 1'b1;
        tick();
        check("t1_rd2", 32'(rd_data), 32'h3C);
        tick();
        check("t1_rd3", 32'(rd_data), 32'h7E);
        check("t1_level1_left", 32'(level), 32'd1);
        tick();
        check("t1_empty_valid", 32'(rd_valid), 32'd0);
        check("t1_empty_data", 32'(rd_data), 32'd0);
        check("t1_empty_level", 32'(level), 32'd0);
        tick();
        check("t1_ready_while_empty", 32'(level), 32'd0);
        rd_ready = 1'b0;

        // Test 2: fill to 16, 17th byte dropped
        rx_dv = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rx_data = 8'(i);
            tick();
        end
        check("t2_level_full", 32'(level), 32'd16);
        check("t2_ovf_before", 32'(overflow), 32'd0);
        rx_data = 8'hFF;
        tick();
        rx_dv = 1'b0;
        check("t2_level_after_drop", 32'(level), 32'd16);
        check("t2_ovf_set", 32'(overflow), 32'd1);
        check("t2_head", 32'(rd_data), 32'h00);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("t2_ovf_clr", 32'(overflow), 32'd0);

        // Test 3: full + write + pop in the same cycle
        rx_dv = 1'b1; rx_data = 8'h55; rd_ready = 1'b1;
        tick();
        rx_dv = 1'b0; rd_ready = 1'b0;
        check("t3_level", 32'(level), 32'd16);
        check("t3_ovf", 32'(overflow), 32'd0);
        rd_ready = 1'b1;
        for (int i = 1; i < 16; i++) begin
            check($sformatf("t2_rd_%0d", i), 32'(rd_data), 32'(i));
            tick();
        end
        check("t3_last", 32'(rd_data), 32'h55);
        tick();
        rd_ready = 1'b0;
        check("t3_empty", 32'(rd_valid), 32'd0);

        // Test 4: 40 write/read pairs across pointer wrap
        for (int i = 0; i < 40; i++) begin
            rx_dv = 1'b1; rx_data = 8'(8'h20 + i);
            tick();
            rx_dv = 1'b0;
            check($sformatf("t4_data_%0d", i), 32'(rd_data), 32'(8'h20 + i));
            check($sformatf("t4_lvl1_%0d", i), 32'(level), 32'd1);
            rd_ready = 1'b1;
            tick();
            rd_ready = 1'b0;
            check($sformatf("t4_lvl0_%0d", i), 32'(level), 32'd0);
        end

        // Test 5: overflow set beats clear; clear alone; async reset
        rx_dv = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rx_data = 8'(8'h80 + i);
            tick();
        end
        rx_data = 8'hEE;
        tick();
        check("t5_ovf_set", 32'(overflow), 32'd1);
        ovf_clr = 1'b1;
        tick();
        check("t5_set_wins", 32'(overflow), 32'd1);
        rx_dv = 1'b0;
        tick();
        ovf_clr = 1'b0;
        check("t5_clr_alone", 32'(overflow), 32'd0);
        check("t5_head", 32'(rd_data), 32'h80);
        rd_ready = 1'b1;
        for (int i = 0; i < 11; i++) tick();
        rd_ready = 1'b0;
        check("t5_level5", 32'(level), 32'd5);
        check("t5_head5", 32'(rd_data), 32'h8B);
        #2;
        rst = 1'b1;
        #1;
        check("t5_rst_level", 32'(level), 32'd0);
        check("t5_rst_valid", 32'(rd_valid), 32'd0);
        check("t5_rst_data", 32'(rd_data), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("t5_post_rst_level", 32'(level), 32'd0);

`ifdef UART_RX_FIFO_IRQ_EN
        // Test 6: threshold interrupt
        thresh = 5'd4;
        rx_dv = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rx_data = 8'(i);
            tick();
        end
        check("t6_irq_lvl3", 32'(irq), 32'd0);
        rx_data = 8'h03;
        tick();
        rx_dv = 1'b0;
        check("t6_irq_rise", 32'(irq), 32'd1);
        tick();
        check("t6_irq_hold", 32'(irq), 32'd1);
        rd_ready = 1'b1;
        tick();
        check("t6_irq_fall", 32'(irq), 32'd0);
        for (int i = 0; i < 3; i++) tick();
        rd_ready = 1'b0;
        check("t6_drained", 32'(level), 32'd0);
        thresh = 5'd0;
        rx_dv = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rx_data = 8'(i);
            tick();
        end
        rx_dv = 1'b0;
        check("t6_thresh0", 32'(irq), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_uart_rx_fifo
